pipe_ctrl_gen: RTL
==================

Name: pipe_ctrl_gen

Overview:
Parametrised pipeline control unit and successor to the fixed 6-stage stall/flush controller. It collects per-stage stall requests and converts the oldest requesting stage into a thermometer stall mask. It also detects exception and eret events, drives a flush that is held for a configurable number of cycles, and produces a redirect PC with a valid strobe. A stall watchdog flags stalls that run for too long. It sits beside the pipeline and drives stall/flush to every stage register plus the PC redirect into IF.

Parameters:
STAGES, 6, number of pipeline stages; bit 0 is PC/IF, higher bits are older stages.
AW, 32, PC/EPC width.
EXC_VECTOR, 32'hBFC00380, redirect target for every non-eret exception.
FLUSH_CYCLES, 1, cycles flush_o is held per event; legal range 1..15.
TO_W, 16, width of the stall watchdog counter.
STALL_TIMEOUT, 1000, consecutive stalled cycles before the timeout pulse; 0 disables the watchdog.

Ports:
clk  in  1  clock; all logic on posedge.
rst  in  1  synchronous reset, active-low.
stallreq_i  in  STAGES  bit s=1: stage s requests a stall.
excepttype_i  in  32  exception code from MEM/CP0 commit; 0 means none.
cp0_epc_i  in  AW  EPC for eret.
stall_o  out  STAGES  per-stage stall, thermometer mask.
flush_o  out  1  flush all stage registers.
new_pc_o  out  AW  redirect target; 0 when there is no redirect.
new_pc_valid_o  out  1  one-cycle strobe for the redirect.
stall_timeout_o  out  1  one-cycle watchdog pulse.

Behaviour:
- All outputs are registered. Inputs sampled at edge N appear after edge N (1-cycle latency).
- Reset (rst==0 at an edge): stall_o=0, flush_o=0, new_pc_o=0, new_pc_valid_o=0, stall_timeout_o=0, state=RUN, counters=0. Reset wins over everything, including mid-flush; the pending flush is dropped.
- FSM states: RUN and FLUSH.
- RUN, excepttype_i!=0:
  - flush_o=1, stall_o=0, new_pc_valid_o=1.
  - Codes 0x1, 0x4, 0x5, 0x8, 0x9, 0xA, 0xC, 0xD and any other nonzero code except 0xE: new_pc_o=EXC_VECTOR.
  - Code 0xE (eret): new_pc_o=cp0_epc_i as sampled at that edge.
  - Load fcnt=FLUSH_CYCLES-1. Go to FLUSH if fcnt!=0, else stay in RUN.
- Exception and stall in the same cycle: the exception wins and the stall is ignored.
- RUN, no exception:
  - flush_o=0, new_pc_o=0, new_pc_valid_o=0.
  - h = highest set bit of stallreq_i; stall_o = bits [h:0] set, the rest clear.
  - stallreq_i==0 gives stall_o=0.
  - Example (STAGES=6): request at stage 3 gives 001111; requests at stages 2 and 3 give 001111.
- FLUSH:
  - flush_o=1, new_pc_o holds its value, new_pc_valid_o=0, stall_o=0.
  - excepttype_i and stallreq_i are ignored.
  - fcnt decrements each cycle. At fcnt==1 the next state is RUN, so flush_o is high for exactly FLUSH_CYCLES cycles.
- First RUN cycle after FLUSH: inputs are evaluated normally. A new exception there starts a new flush and a new strobe.
- Watchdog (STALL_TIMEOUT!=0):
  - tcnt increments on every cycle in which stall_o!=0 is registered.
  - tcnt clears when stall_o==0 or flush_o==1.
  - tcnt saturates at all-ones.
  - stall_timeout_o=1 for the single cycle in which tcnt reaches STALL_TIMEOUT, never again until tcnt has cleared.
  - With STALL_TIMEOUT=0, stall_timeout_o is constant 0.
- Width rules: new_pc_o and cp0_epc_i are AW bits; EXC_VECTOR is truncated to AW. fcnt is 4 bits. tcnt is TO_W bits and STALL_TIMEOUT must be < 2**TO_W.

Decomposition:
- Shared package pipe_ctrl_pkg holds:
  - exception code constants (EXC_INT=0x1, EXC_ADEL=0x4, EXC_ADES=0x5, EXC_SYS=0x8, EXC_BP=0x9, EXC_RI=0xA, EXC_OV=0xC, EXC_TR=0xD, EXC_ERET=0xE);
  - the state encoding (RUN, FLUSH);
  - the default EXC_VECTOR.
- One sub-module, stall_mask_enc (parameter STAGES): purely combinational highest-set-bit to thermometer-mask encoder. Instantiated once; the outputs are registered in the parent.

Test Plan:
- Reset with rst=0 for 2 cycles while stallreq_i=6'b111111 and excepttype_i=0x8 -> every output stays 0 during reset and for the first edge after rst returns to 1 has not yet been sampled.
- stallreq_i=6'b000100, then 6'b001100, then 0 -> stall_o=000111, then 001111, then 000000, each one cycle after its input; flush_o=0 throughout.
- excepttype_i=0x8 with stallreq_i=6'b001000 in the same cycle -> next cycle flush_o=1, stall_o=0, new_pc_o=BFC00380, new_pc_valid_o=1; following cycle flush_o=0, new_pc_o=0.
- excepttype_i=0xE with cp0_epc_i=0x80001234 -> new_pc_o=0x80001234 and a one-cycle new_pc_valid_o.
- FLUSH_CYCLES=3: excepttype_i=0xC, then 0x4 on the next cycle -> flush_o high exactly 3 cycles, a single strobe, new_pc_o=BFC00380 held for 3 cycles, the second exception ignored. Drop rst mid-flush on a separate run -> all outputs 0 on the next edge.
- STALL_TIMEOUT=5: hold stallreq_i=6'b000001 for 10 cycles -> stall_timeout_o pulses once on the 5th stalled output cycle; release for 1 cycle and re-stall -> the pulse recurs after 5 more cycles.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline control unit: exception codes,
// controller states and the default exception vector.
package pipe_ctrl_pkg;

    localparam logic [31:0] EXC_INT  = 32'h1;
    localparam logic [31:0] EXC_ADEL = 32'h4;
    localparam logic [31:0] EXC_ADES = 32'h5;
    localparam logic [31:0] EXC_SYS  = 32'h8;
    localparam logic [31:0] EXC_BP   = 32'h9;
    localparam logic [31:0] EXC_RI   = 32'hA;
    localparam logic [31:0] EXC_OV   = 32'hC;
    localparam logic [31:0] EXC_TR   = 32'hD;
    localparam logic [31:0] EXC_ERET = 32'hE;

    localparam logic [31:0] DEF_EXC_VECTOR = 32'hBFC00380;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_FLUSH = 1'b1
    } state_t;

    // Only eret returns to the EPC; every other nonzero code goes to the vector.
    function automatic logic is_eret(input logic [31:0] code);
        logic r;
        case (code)
            EXC_INT, EXC_ADEL, EXC_ADES, EXC_SYS,
            EXC_BP, EXC_RI, EXC_OV, EXC_TR: r = 1'b0;
            EXC_ERET:                       r = 1'b1;
            default:                        r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/pipe_ctrl_gen_stall_mask_enc.sv
// Combinational encoder: highest requesting stage -> thermometer stall mask
// covering that stage and every younger stage below it.
module stall_mask_enc #(
    parameter int STAGES = 6
) (
    input  logic [STAGES-1:0] req,
    output logic [STAGES-1:0] mask
);

    always_comb begin
        mask = '0;
        for (int i = 0; i < STAGES; i++) begin
            mask[i] = |(req >> i);
        end
    end

endmodule

// File: rtl/pipe_ctrl_gen.sv
// Pipeline stall/flush controller: thermometer stall mask, timed flush with
// PC redirect on exception/eret, and a stall watchdog. All outputs registered.
module pipe_ctrl_gen
    import pipe_ctrl_pkg::*;
#(
    parameter int          STAGES        = 6,
    parameter int          AW            = 32,
    parameter logic [31:0] EXC_VECTOR    = DEF_EXC_VECTOR,
    parameter int          FLUSH_CYCLES  = 1,
    parameter int          TO_W          = 16,
    parameter int          STALL_TIMEOUT = 1000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [STAGES-1:0] stallreq_i,
    input  logic [31:0]       excepttype_i,
    input  logic [AW-1:0]     cp0_epc_i,
    output logic [STAGES-1:0] stall_o,
    output logic              flush_o,
    output logic [AW-1:0]     new_pc_o,
    output logic              new_pc_valid_o,
    output logic              stall_timeout_o
);

    localparam logic [AW-1:0]   VEC_PC    = AW'(EXC_VECTOR);
    localparam logic [3:0]      FCNT_LOAD = 4'(FLUSH_CYCLES - 1);
    localparam logic [TO_W-1:0] TO_LIMIT  = TO_W'(STALL_TIMEOUT);
    localparam bit              WD_EN     = (STALL_TIMEOUT != 0);

    state_t            state_q, state_d;
    logic [3:0]        fcnt_q, fcnt_d;
    logic [TO_W-1:0]   tcnt_q, tcnt_d;
    logic [STAGES-1:0] mask, stall_d;
    logic              flush_d, valid_d, tout_d;
    logic [AW-1:0]     pc_d;

    stall_mask_enc #(.STAGES(STAGES)) u_mask (
        .req  (stallreq_i),
        .mask (mask)
    );

    // NOTE: every always_comb output gets a default first so no path leaves it
    // unassigned; a missing default infers a latch.
    always_comb begin
        state_d = state_q;
        fcnt_d  = fcnt_q;
        stall_d = '0;
        flush_d = 1'b0;
        valid_d = 1'b0;
        pc_d    = '0;
        case (state_q)
            ST_RUN: begin
                if (excepttype_i != '0) begin
                    flush_d = 1'b1;
                    valid_d = 1'b1;
                    pc_d    = is_eret(excepttype_i) ? cp0_epc_i : VEC_PC;
                    fcnt_d  = FCNT_LOAD;
                    state_d = (FCNT_LOAD != 4'd0) ? ST_FLUSH : ST_RUN;
                end else begin
                    stall_d = mask;
                end
            end
            ST_FLUSH: begin
                flush_d = 1'b1;
                pc_d    = new_pc_o;
                fcnt_d  = fcnt_q - 4'd1;
                if (fcnt_q == 4'd1) state_d = ST_RUN;
            end
        endcase

        // Watchdog counts registered stalled cycles; pulse only on the crossing.
        if (stall_d != '0 && !flush_d) begin
            tcnt_d = (&tcnt_q) ? tcnt_q : tcnt_q + TO_W'(1);
        end else begin
            tcnt_d = '0;
        end
        tout_d = WD_EN && (tcnt_d == TO_LIMIT) && (tcnt_q != TO_LIMIT);
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q         <= ST_RUN;
            fcnt_q          <= '0;
            tcnt_q          <= '0;
            stall_o         <= '0;
            flush_o         <= 1'b0;
            new_pc_o        <= '0;
            new_pc_valid_o  <= 1'b0;
            stall_timeout_o <= 1'b0;
        end else begin
            state_q         <= state_d;
            fcnt_q          <= fcnt_d;
            tcnt_q          <= tcnt_d;
            stall_o         <= stall_d;
            flush_o         <= flush_d;
            new_pc_o        <= pc_d;
            new_pc_valid_o  <= valid_d;
            stall_timeout_o <= tout_d;
        end
    end

endmodule
